// File: rtl/mac_tx_scheduler_pkg.sv
// mac_tx_scheduler_pkg
//   Shared definitions for the MAC TX scheduler slice: source-select
//   encodings driven on mac_tx_sel, the scheduler state encoding, default
//   timing constants and the fixed-priority winner function.
package mac_tx_scheduler_pkg;

  // Source mux select as seen by the MAC TX framer.
  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_ARP  = 2'b01,
    SEL_ICMP = 2'b10,
    SEL_UDP  = 2'b11
  } tx_sel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    BUSY  = 2'b10,
    IFG   = 2'b11
  } tx_state_e;

  // One byte per cycle, so the 12-byte Ethernet gap is 12 cycles.
  localparam int unsigned DEFAULT_IFG_CYCLES   = 12;
  localparam int unsigned DEFAULT_UDP_MAX_SKIP = 4;

  // ARP > ICMP > UDP, unless UDP has been passed over too often.
  function automatic tx_sel_e pick_winner(input logic arp_req,
                                          input logic icmp_req,
                                          input logic udp_req,
                                          input logic udp_promote);
    if (udp_promote)   return SEL_UDP;
    else if (arp_req)  return SEL_ARP;
    else if (icmp_req) return SEL_ICMP;
    else if (udp_req)  return SEL_UDP;
    else               return SEL_NONE;
  endfunction

endpackage

// File: rtl/mac_tx_gap_timer.sv
// mac_tx_gap_timer
//   Loadable down-counter with a done flag. Counts down by one per enabled
//   cycle and stops at zero; done is high while the count is zero.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this cycle (takes priority over en)
//   load_val    value loaded; done rises load_val enabled cycles later
//   en          decrement enable
//   done        count is zero
module mac_tx_gap_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (en && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler
//   Arbitrates the shared MAC TX path among ARP reply, ICMP echo reply and
//   UDP user-data sources. One source is granted per frame (ack + framer
//   start pulse), its select is held until the framer reports frame end,
//   then IFG_CYCLES idle cycles are inserted. Priority ARP > ICMP > UDP with
//   UDP promoted after UDP_MAX_SKIP consecutive grants to others.
// Optional build macro: TX_TIMEOUT_EN enables a BUSY watchdog that pulses
//   tx_timeout and forces the gap after TX_TIMEOUT_CYCLES busy cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   *_tx_req / *_tx_ack   source request (held until ack) / 1-cycle grant
//   mac_tx_start          1-cycle framer start, coincident with the ack
//   mac_tx_sel            00 none, 01 ARP, 10 ICMP, 11 UDP
//   mac_tx_end            framer pulse: last byte (incl. CRC) sent
//   mac_tx_busy           high in START, BUSY and IFG
//   tx_timeout            1-cycle watchdog pulse (0 without TX_TIMEOUT_EN)
module mac_tx_scheduler
  import mac_tx_scheduler_pkg::*;
#(
  parameter int unsigned IFG_CYCLES        = DEFAULT_IFG_CYCLES,
  parameter int unsigned UDP_MAX_SKIP      = DEFAULT_UDP_MAX_SKIP,
  parameter int unsigned TX_TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arp_tx_req,
  output logic       arp_tx_ack,
  input  logic       icmp_tx_req,
  output logic       icmp_tx_ack,
  input  logic       udp_tx_req,
  output logic       udp_tx_ack,
  output logic       mac_tx_start,
  output logic [1:0] mac_tx_sel,
  input  logic       mac_tx_end,
  output logic       mac_tx_busy,
  output logic       tx_timeout
);

  localparam int unsigned IFG_W    = $clog2(IFG_CYCLES + 1);
  localparam logic [2:0]  SKIP_MAX = 3'(UDP_MAX_SKIP);

  tx_state_e  state_q, state_d;
  tx_sel_e    winner_q, winner_d;
  logic [2:0] skip_cnt_q, skip_cnt_d;

  tx_sel_e    win;
  logic       udp_promote;
  logic       ifg_load;
  logic       ifg_done;

`ifdef TX_TIMEOUT_EN
  logic       wd_load;
  logic       wd_done;
  logic       timeout_fire;
`endif

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    skip_cnt_d  = skip_cnt_q;
    ifg_load    = 1'b0;
`ifdef TX_TIMEOUT_EN
    wd_load      = 1'b0;
    timeout_fire = 1'b0;
`endif
    udp_promote = (skip_cnt_q == SKIP_MAX) && udp_tx_req;
    win         = pick_winner(arp_tx_req, icmp_tx_req, udp_tx_req, udp_promote);

    case (state_q)
      IDLE: begin
        if (arp_tx_req || icmp_tx_req || udp_tx_req) begin
          state_d  = START;
          winner_d = win;
          // The skip count tracks grants that passed over a waiting UDP.
          if (win == SEL_UDP || !udp_tx_req) skip_cnt_d = '0;
          else if (skip_cnt_q < SKIP_MAX)    skip_cnt_d = skip_cnt_q + 3'd1;
        end
      end
      START: begin
        if (mac_tx_end) begin
          state_d  = IFG;
          ifg_load = 1'b1;
        end else begin
          state_d = BUSY;
`ifdef TX_TIMEOUT_EN
          wd_load = 1'b1;
`endif
        end
      end
      BUSY: begin
        if (mac_tx_end) begin
          state_d  = IFG;
          ifg_load = 1'b1;
        end
`ifdef TX_TIMEOUT_EN
        else if (wd_done) begin
          timeout_fire = 1'b1;
          state_d      = IFG;
          ifg_load     = 1'b1;
        end
`endif
      end
      IFG: begin
        if (ifg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= SEL_NONE;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      winner_q   <= winner_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Loaded with IFG_CYCLES-1 on frame end so done is seen in the last gap cycle.
  mac_tx_gap_timer #(
    .WIDTH (IFG_W)
  ) u_ifg_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifg_load),
    .load_val (IFG_W'(IFG_CYCLES - 1)),
    .en       (state_q == IFG),
    .done     (ifg_done)
  );

`ifdef TX_TIMEOUT_EN
  // Fires in the TX_TIMEOUT_CYCLES-th BUSY cycle; a coincident frame end wins.
  mac_tx_gap_timer #(
    .WIDTH (13)
  ) u_wd_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wd_load),
    .load_val (13'(TX_TIMEOUT_CYCLES - 1)),
    .en       (state_q == BUSY),
    .done     (wd_done)
  );
  assign tx_timeout = timeout_fire;
`else
  assign tx_timeout = 1'b0;
`endif

  assign mac_tx_busy  = (state_q != IDLE);
  assign mac_tx_start = (state_q == START);
  assign mac_tx_sel   = (state_q == START || state_q == BUSY) ? winner_q : SEL_NONE;
  assign arp_tx_ack   = (state_q == START) && (winner_q == SEL_ARP);
  assign icmp_tx_ack  = (state_q == START) && (winner_q == SEL_ICMP);
  assign udp_tx_ack   = (state_q == START) && (winner_q == SEL_UDP);

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb_mac_tx_scheduler
//   Scenario bench for mac_tx_scheduler. Expected grant order is queued when
//   requests are raised and compared as grants appear; cycle-exact scenarios
//   compare the output vector every cycle against hand-derived timing.
module tb_mac_tx_scheduler;
  import mac_tx_scheduler_pkg::*;

  localparam int unsigned IFG    = 12;
  localparam int unsigned TO_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arp_tx_req = 1'b0, icmp_tx_req = 1'b0, udp_tx_req = 1'b0;
  logic       mac_tx_end = 1'b0;
  logic       arp_tx_ack, icmp_tx_ack, udp_tx_ack;
  logic       mac_tx_start, mac_tx_busy, tx_timeout;
  logic [1:0] mac_tx_sel;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs_sel[$];
  int         obs_cyc[$];
  bit         obs_ack_ok[$];

  always #5 clk = ~clk;

  mac_tx_scheduler #(
    .IFG_CYCLES        (IFG),
    .UDP_MAX_SKIP      (4),
    .TX_TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arp_tx_req   (arp_tx_req),
    .arp_tx_ack   (arp_tx_ack),
    .icmp_tx_req  (icmp_tx_req),
    .icmp_tx_ack  (icmp_tx_ack),
    .udp_tx_req   (udp_tx_req),
    .udp_tx_ack   (udp_tx_ack),
    .mac_tx_start (mac_tx_start),
    .mac_tx_sel   (mac_tx_sel),
    .mac_tx_end   (mac_tx_end),
    .mac_tx_busy  (mac_tx_busy),
    .tx_timeout   (tx_timeout)
  );

  // Outputs are sampled and inputs driven at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Framer/source model: records every grant, ends each frame flen cycles
  // after its start, drops non-persistent requests on their ack.
  task automatic serve(input int n, input int flen, input bit p_arp,
                       input bit p_icmp, input bit p_udp, input int budget);
    int got = 0;
    int end_at = -1;
    int c = 0;
    bit done = 1'b0;
    logic [2:0] exp_ack;
    while (!done && c < budget) begin
      step();
      c++;
      mac_tx_end = 1'b0;
      if (mac_tx_start) begin
        case (mac_tx_sel)
          2'b01:   exp_ack = 3'b001;
          2'b10:   exp_ack = 3'b010;
          2'b11:   exp_ack = 3'b100;
          default: exp_ack = 3'b111;
        endcase
        obs_sel.push_back(mac_tx_sel);
        obs_cyc.push_back(c);
        obs_ack_ok.push_back({udp_tx_ack, icmp_tx_ack, arp_tx_ack} == exp_ack);
        got++;
        end_at = c + flen;
        if (arp_tx_ack && !p_arp)   arp_tx_req = 1'b0;
        if (icmp_tx_ack && !p_icmp) icmp_tx_req = 1'b0;
        if (udp_tx_ack && !p_udp)   udp_tx_req = 1'b0;
      end
      if (c == end_at) mac_tx_end = 1'b1;
      if (got == n && c > end_at && !mac_tx_busy) done = 1'b1;
    end
    mac_tx_end = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL serve_timeout: got %0d grants, required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    vectors++;
    if ({arp_tx_ack, icmp_tx_ack, udp_tx_ack, mac_tx_start, mac_tx_sel,
         mac_tx_busy, tx_timeout} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected 00000000",
               {arp_tx_ack, icmp_tx_ack, udp_tx_ack, mac_tx_start, mac_tx_sel,
                mac_tx_busy, tx_timeout});
    end
    rst_n = 1'b1;
    step();
  endtask

  // {arp_ack, icmp_ack, udp_ack, start, sel[1:0], busy, timeout}
  task automatic test_single_arp();
    logic [7:0] got, exp;
    step();
    arp_tx_req = 1'b1;
    for (int c = 1; c <= 54; c++) begin
      step();
      exp = {c == 1, 1'b0, 1'b0, c == 1, (c <= 40) ? SEL_ARP : SEL_NONE,
             c <= 52, 1'b0};
      got = {arp_tx_ack, icmp_tx_ack, udp_tx_ack, mac_tx_start, mac_tx_sel,
             mac_tx_busy, tx_timeout};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL single_arp c=%0d: got %b, expected %b", c, got, exp);
      end
      if (arp_tx_ack) arp_tx_req = 1'b0;
      mac_tx_end = (c == 40);
    end
    mac_tx_end = 1'b0;
  endtask

  task automatic test_all_three();
    logic [1:0] e, s;
    int cc, prev;
    bit ok;
    arp_tx_req = 1'b1; icmp_tx_req = 1'b1; udp_tx_req = 1'b1;
    exp_q.push_back(SEL_ARP); exp_q.push_back(SEL_ICMP); exp_q.push_back(SEL_UDP);
    serve(3, 20, 1'b0, 1'b0, 1'b0, 400);
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_sel.size() == 0) begin
        miscompares++;
        $display("FAIL all_three_grant%0d: got no grant, expected sel %b", i, e);
      end else begin
        s = obs_sel.pop_front(); cc = obs_cyc.pop_front(); ok = obs_ack_ok.pop_front();
        if (s !== e) begin
          miscompares++;
          $display("FAIL all_three_sel%0d: got %b, expected %b", i, s, e);
        end
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL all_three_ack%0d: got ack not matching sel %b, expected one-hot", i, s);
        end
        if (i > 0) begin
          vectors++;
          if (cc - prev != 20 + IFG + 2) begin
            miscompares++;
            $display("FAIL all_three_spacing%0d: got %0d, expected %0d", i, cc - prev, 20 + IFG + 2);
          end
        end
        prev = cc;
      end
    end
  endtask

  // All sources persistent: UDP is promoted after four ARP grants, and the
  // pattern repeats only if the skip count went back to zero.
  task automatic test_starvation();
    logic [1:0] e, s;
    int cc, prev;
    bit ok;
    obs_sel.delete(); obs_cyc.delete(); obs_ack_ok.delete(); exp_q.delete();
    arp_tx_req = 1'b1; icmp_tx_req = 1'b1; udp_tx_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(SEL_ARP);
      exp_q.push_back(SEL_UDP);
    end
    serve(10, 6, 1'b1, 1'b1, 1'b1, 800);
    arp_tx_req = 1'b0; icmp_tx_req = 1'b0; udp_tx_req = 1'b0;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_sel.size() == 0) begin
        miscompares++;
        $display("FAIL starve_grant%0d: got no grant, expected sel %b", i, e);
      end else begin
        s = obs_sel.pop_front(); cc = obs_cyc.pop_front(); ok = obs_ack_ok.pop_front();
        if (s !== e) begin
          miscompares++;
          $display("FAIL starve_sel%0d: got %b, expected %b", i, s, e);
        end
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL starve_ack%0d: got ack not matching sel %b, expected one-hot", i, s);
        end
        if (i > 0) begin
          vectors++;
          if (cc - prev != 6 + IFG + 2) begin
            miscompares++;
            $display("FAIL starve_spacing%0d: got %0d, expected %0d", i, cc - prev, 6 + IFG + 2);
          end
        end
        prev = cc;
      end
    end
  endtask

  // ICMP pulses inside the gap and is gone by IDLE; stray frame-end pulses
  // in IFG and IDLE must not disturb the timing.
  task automatic test_withdrawal();
    logic [7:0] got, exp;
    step();
    arp_tx_req = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      exp = {c == 1, 1'b0, 1'b0, c == 1, (c <= 5) ? SEL_ARP : SEL_NONE,
             c <= 17, 1'b0};
      got = {arp_tx_ack, icmp_tx_ack, udp_tx_ack, mac_tx_start, mac_tx_sel,
             mac_tx_busy, tx_timeout};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL withdrawal c=%0d: got %b, expected %b", c, got, exp);
      end
      if (arp_tx_ack) arp_tx_req = 1'b0;
      mac_tx_end  = (c == 5 || c == 10 || c == 22);
      icmp_tx_req = (c >= 8 && c <= 15);
    end
    mac_tx_end = 1'b0;
    icmp_tx_req = 1'b0;
  endtask

  // Frame end coincident with START goes straight to the gap.
  task automatic test_back_to_back();
    logic [1:0] e, s;
    int cc, prev;
    bit ok;
    obs_sel.delete(); obs_cyc.delete(); obs_ack_ok.delete(); exp_q.delete();
    icmp_tx_req = 1'b1; udp_tx_req = 1'b1;
    exp_q.push_back(SEL_ICMP); exp_q.push_back(SEL_UDP);
    serve(2, 0, 1'b0, 1'b0, 1'b0, 200);
    prev = 0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_sel.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_grant%0d: got no grant, expected sel %b", i, e);
      end else begin
        s = obs_sel.pop_front(); cc = obs_cyc.pop_front(); ok = obs_ack_ok.pop_front();
        if (s !== e) begin
          miscompares++;
          $display("FAIL b2b_sel%0d: got %b, expected %b", i, s, e);
        end
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL b2b_ack%0d: got ack not matching sel %b, expected one-hot", i, s);
        end
        if (i > 0) begin
          vectors++;
          if (cc - prev != IFG + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d, expected %0d", cc - prev, IFG + 2);
          end
        end
        prev = cc;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c = 0;
    udp_tx_req = 1'b1;
    do begin
      step();
      c++;
    end while (!mac_tx_start && c < 20);
    vectors++;
    if (!mac_tx_start || mac_tx_sel !== SEL_UDP) begin
      miscompares++;
      $display("FAIL rmf_grant: got start=%b sel=%b, expected start=1 sel=11", mac_tx_start, mac_tx_sel);
    end
    for (int k = 0; k < 10; k++) step();
    vectors++;
    if (mac_tx_sel !== SEL_UDP || !mac_tx_busy) begin
      miscompares++;
      $display("FAIL rmf_midframe: got sel=%b busy=%b, expected sel=11 busy=1", mac_tx_sel, mac_tx_busy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({arp_tx_ack, icmp_tx_ack, udp_tx_ack, mac_tx_start, mac_tx_sel,
         mac_tx_busy, tx_timeout} !== 8'h00) begin
      miscompares++;
      $display("FAIL rmf_async_reset: got %b, expected 00000000",
               {arp_tx_ack, icmp_tx_ack, udp_tx_ack, mac_tx_start, mac_tx_sel,
                mac_tx_busy, tx_timeout});
    end
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if ({udp_tx_ack, mac_tx_start, mac_tx_sel} !== 4'b1111) begin
      miscompares++;
      $display("FAIL rmf_regrant: got ack/start/sel %b, expected 1111",
               {udp_tx_ack, mac_tx_start, mac_tx_sel});
    end
    udp_tx_req = 1'b0;
    step();
    mac_tx_end = 1'b1;
    step();
    mac_tx_end = 1'b0;
    c = 0;
    while (mac_tx_busy && c < 30) begin
      step();
      c++;
    end
    vectors++;
    if (mac_tx_busy) begin
      miscompares++;
      $display("FAIL rmf_idle: got busy=1 after %0d cycles, expected 0", c);
    end
  endtask

`ifdef TX_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] got, exp;
    step();
    arp_tx_req = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      step();
      exp = {c == 65, c <= 77, c <= 65};
      got = {tx_timeout, mac_tx_busy, mac_tx_sel == SEL_ARP};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL timeout c=%0d: got %b, expected %b", c, got, exp);
      end
      if (arp_tx_ack) arp_tx_req = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_arp();
    test_all_three();
    test_starvation();
    test_withdrawal();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
